// File: rtl/lfsr_pkg.sv
// Shared constants and types for the LFSR tap-pattern search.
//   NUM_TAPS  : number of candidate maximal-length tap patterns (indices 0..NUM_TAPS-1)
//   TAP_W     : tap counter width; NUM_TAPS must be <= 2**TAP_W - 1 so the
//               all-ones value stays free to mean "no match"
//   DAT_W     : LFSR state width
//   TAP_MASKS : the candidate 7-bit tap masks, in index order (used by LUT models)
package lfsr_pkg;

  localparam int NUM_TAPS = 9;
  localparam int TAP_W    = 4;
  localparam int DAT_W    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } search_state_t;

  localparam logic [TAP_W-1:0] TAP_NONE = '1;

  localparam logic [DAT_W-1:0] TAP_MASKS [NUM_TAPS] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

endpackage

// File: rtl/lfsr_tap_search_ctrl.sv
// Sequencer that scans the external tap-pattern LUT to find which tap pattern
// steps a latched seed to a latched target.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : request pulse, only sampled while idle
//   seed       : LFSR state before the step (latched on accept)
//   target     : expected LFSR state after the step (latched on accept)
//   lut_addr   : {tap counter, latched seed} to the LUT (registered)
//   lut_data   : LUT read data, combinational from lut_addr
//   busy       : high whenever the sequencer is not idle
//   done       : one-cycle pulse when found/tap_idx/match_mask are valid
//   found      : a match was found; held until the next accepted start
//   tap_idx    : matching index, all-ones on no match; held
//   match_mask : per-index match bits (all-match build only, else 0)
//
// Build option: define LFSR_ALL_MATCH_EN to always scan every index and
// collect every hit in match_mask; tap_idx then reports the lowest hit.
// Without it the scan stops at the first (lowest) matching index.
module lfsr_tap_search_ctrl
  import lfsr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DAT_W-1:0]       seed,
  input  logic [DAT_W-1:0]       target,
  output logic [TAP_W+DAT_W-1:0] lut_addr,
  input  logic [DAT_W-1:0]       lut_data,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [TAP_W-1:0]       tap_idx,
  output logic [NUM_TAPS-1:0]    match_mask
);

  localparam logic [TAP_W-1:0] LAST_IDX = TAP_W'(NUM_TAPS - 1);

  search_state_t    state_reg;
  logic [TAP_W-1:0] idx_reg;
  logic [DAT_W-1:0] seed_reg;
  logic [DAT_W-1:0] target_reg;
  logic             found_reg;
  logic [TAP_W-1:0] tap_idx_reg;
  logic             hit;
  logic             last;

  assign hit  = (lut_data == target_reg);
  assign last = (idx_reg == LAST_IDX);

`ifdef LFSR_ALL_MATCH_EN
  logic [NUM_TAPS-1:0] mask_reg;
  assign match_mask = mask_reg;
`else
  assign match_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      seed_reg    <= '0;
      target_reg  <= '0;
      found_reg   <= 1'b0;
      tap_idx_reg <= '1;
`ifdef LFSR_ALL_MATCH_EN
      mask_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            seed_reg   <= seed;
            target_reg <= target;
            idx_reg    <= '0;
            found_reg  <= 1'b0;
`ifdef LFSR_ALL_MATCH_EN
            mask_reg   <= '0;
`endif
            state_reg  <= SCAN;
          end
        end

        SCAN: begin
`ifdef LFSR_ALL_MATCH_EN
          // Visit every index; the first hit seen is the lowest index because
          // the counter only counts up.
          if (hit) begin
            mask_reg[idx_reg] <= 1'b1;
            if (!found_reg) begin
              tap_idx_reg <= idx_reg;
              found_reg   <= 1'b1;
            end
          end
          if (last) begin
            if (!found_reg && !hit) begin
              tap_idx_reg <= '1;
            end
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
`else
          if (hit) begin
            tap_idx_reg <= idx_reg;
            found_reg   <= 1'b1;
            state_reg   <= DONE;
          end else if (last) begin
            tap_idx_reg <= '1;
            found_reg   <= 1'b0;
            state_reg   <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
`endif
        end

        DONE: begin
          // start is deliberately ignored here; a held start is taken in IDLE.
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Address comes only from registers, so the LUT sees no path from seed.
  assign lut_addr = {idx_reg, seed_reg};
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign found    = found_reg;
  assign tap_idx  = tap_idx_reg;

endmodule

// File: tb/tb_lfsr_tap_search_ctrl.sv
`timescale 1ns/1ps
module tb_lfsr_tap_search_ctrl;
  import lfsr_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [DAT_W-1:0]       seed = '0;
  logic [DAT_W-1:0]       target = '0;
  logic [TAP_W+DAT_W-1:0] lut_addr;
  logic [DAT_W-1:0]       lut_data;
  logic                   busy;
  logic                   done;
  logic                   found;
  logic [TAP_W-1:0]       tap_idx;
  logic [NUM_TAPS-1:0]    match_mask;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic                found;
    logic [TAP_W-1:0]    idx;
    int                  lat;
    logic [NUM_TAPS-1:0] mask;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lfsr_tap_search_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .target     (target),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .tap_idx    (tap_idx),
    .match_mask (match_mask)
  );

  // LUT model: one Galois right-shift step of the LFSR with the selected mask.
  function automatic logic [DAT_W-1:0] lut_model(input logic [TAP_W+DAT_W-1:0] a);
    logic [TAP_W-1:0] k;
    logic [DAT_W-1:0] s;
    k = a[TAP_W+DAT_W-1:DAT_W];
    s = a[DAT_W-1:0];
    if (int'(k) >= NUM_TAPS) return '0;
    return (s >> 1) ^ (s[0] ? TAP_MASKS[k] : '0);
  endfunction

  assign lut_data = lut_model(lut_addr);

  // Latency is counted in clock edges from the start-sampling edge (inclusive)
  // to the edge after which done is seen.
  function automatic exp_t predict(input logic [DAT_W-1:0] s, input logic [DAT_W-1:0] t);
    exp_t e;
    e.found = 1'b0;
    e.idx   = '1;
    e.mask  = '0;
    e.lat   = NUM_TAPS + 1;
    for (int k = NUM_TAPS - 1; k >= 0; k--) begin
      if (lut_model({TAP_W'(k), s}) == t) begin
        e.found   = 1'b1;
        e.idx     = TAP_W'(k);
        e.mask[k] = 1'b1;
      end
    end
`ifndef LFSR_ALL_MATCH_EN
    e.mask = '0;
    if (e.found) e.lat = int'(e.idx) + 2;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after the edge that accepted start. Follows the scan, pops the
  // scoreboard on done and compares. Optionally pokes start/seed/target
  // mid-scan, and optionally leaves start high through the DONE cycle.
  task automatic wait_result(input string tag, input logic [DAT_W-1:0] s,
                             input int mid_cyc, input bit hold_start);
    exp_t e;
    int   cyc;
    cyc = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 40) begin
      check({tag, "_addr"}, 32'(lut_addr), 32'({TAP_W'(cyc - 1), s}));
      if (cyc == mid_cyc) begin
        start  = 1'b1;
        seed   = ~s;
        target = ~target;
      end else if (cyc == mid_cyc + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
      check({tag, "_found"}, 32'(found), 32'(e.found));
      check({tag, "_tap_idx"}, 32'(tap_idx), 32'(e.idx));
      check({tag, "_mask"}, 32'(match_mask), 32'(e.mask));
      if (hold_start) start = 1'b1;
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_found_held"}, 32'(found), 32'(e.found));
      check({tag, "_idx_held"}, 32'(tap_idx), 32'(e.idx));
    end
    $display("search %s seed=%h exp_found=%0d exp_idx=%0d got_found=%0d got_idx=%0d cycles=%0d",
             tag, s, e.found, e.idx, found, tap_idx, cyc);
  endtask

  task automatic run_search(input string tag, input logic [DAT_W-1:0] s,
                            input logic [DAT_W-1:0] t, input int mid_cyc,
                            input bit hold_start);
    sb.push_back(predict(s, t));
    seed   = s;
    target = t;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_result(tag, s, mid_cyc, hold_start);
  endtask

  initial begin
    logic [DAT_W-1:0] s_r;
    logic [DAT_W-1:0] t_r;
    logic [DAT_W-1:0] held_seed;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_tap_idx", 32'(tap_idx), 32'(TAP_NONE));
    check("rst_lut_addr", 32'(lut_addr), 32'd0);
    check("rst_mask", 32'(match_mask), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Unique match at index 3
    run_search("match3", 7'h01, lut_model({4'd3, 7'h01}), -1, 1'b0);
    // Unreachable target: full scan, no match
    run_search("nomatch", 7'h01, 7'h00, -1, 1'b0);
    // Even seed: every pattern matches, lowest index must win
    run_search("lowest", 7'h02, 7'h01, -1, 1'b0);
    // Match at the last valid index
    run_search("last", 7'h55, lut_model({4'd8, 7'h55}), -1, 1'b0);

    // start and seed/target disturbed mid-scan; start then held through DONE
    run_search("midscan", 7'h01, lut_model({4'd6, 7'h01}), 2, 1'b1);
    held_seed = seed;
    sb.push_back(predict(seed, target));
    check("held_start_accept_pending", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_result("heldstart", held_seed, -1, 1'b0);

    // Reset while scanning at idx 5
    seed   = 7'h01;
    target = 7'h00;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_idx", 32'(lut_addr[TAP_W+DAT_W-1:DAT_W]), 32'd5);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_found", 32'(found), 32'd0);
    check("midrst_tap_idx", 32'(tap_idx), 32'(TAP_NONE));
    check("midrst_lut_addr", 32'(lut_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", 32'(done), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_search("after_rst", 7'h33, lut_model({4'd4, 7'h33}), -1, 1'b0);

    // A few random pairs, target usually taken from a random row
    for (int i = 0; i < 4; i++) begin
      s_r = 7'($urandom_range(0, 127));
      t_r = (i == 3) ? 7'($urandom_range(0, 127))
                     : lut_model({4'($urandom_range(0, NUM_TAPS - 1)), s_r});
      run_search("rand", s_r, t_r, -1, 1'b0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
